// File: rtl/button_event_gen.sv
// button_event_gen: synchronise and debounce an active-low button, emit press/release/click/long/repeat strobes
module button_event_gen #(
    parameter int unsigned DEBOUNCE_CYC = 300000,
    parameter int unsigned LONG_CYC     = 15000000,
    parameter int unsigned REPEAT_CYC   = 3000000
) (
    input  logic clk30,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, LONG, DB_RELEASE} state_t;
    localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
    localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYC - 1);
    state_t state;
    logic [31:0] cnt;
    logic was_long, s1, s2, btn_s;
    assign btn_s = ~s2;
    always_ff @(posedge clk30 or posedge rst)
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    always_ff @(posedge clk30 or posedge rst)
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            was_long      <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            cnt           <= cnt + 32'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (btn_s) state <= DB_PRESS;
                end
                DB_PRESS:
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        pressed     <= 1'b1;
                    end
                HELD:
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG;
                        cnt        <= '0;
                        was_long   <= 1'b1;
                        long_pulse <= 1'b1;
                    end
                LONG:
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end
                DB_RELEASE:
                    // a bounce resumes the hold phase with its timer restarted
                    if (btn_s) begin
                        state <= was_long ? LONG : HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        click_pulse   <= ~was_long;
                        was_long      <= 1'b0;
                        pressed       <= 1'b0;
                    end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: random and directed button patterns checked against a run-length reference model
module tb_button_event_gen;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;
    logic clk30 = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;
    logic pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;
    int n_vec = 0;
    int n_err = 0;
    logic q[$];
    logic pl, wl, prev_s;
    int run, anchor, t;

    button_event_gen #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R)) dut (
        .clk30(clk30), .rst(rst), .btn_n(btn_n), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .click_pulse(click_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk30 = ~clk30;

    function automatic logic [5:0] outs();
        return {pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b (pressed,press,release,click,long,repeat)", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pl = 0;
        wl = 0;
        prev_s = 0;
        run = 0;
        anchor = 0;
        t = 0;
    endtask

    // The debounced level flips once the synchronised level has held D+1 samples;
    // hold/repeat timing is measured from the press or from the end of the last bounce.
    task automatic step(input logic b, input string tag);
        logic s;
        logic [5:0] e;
        btn_n = b;
        @(posedge clk30);
        s = (q.size() >= 2) ? !q[q.size()-2] : 1'b0;
        q.push_back(b);
        if (q.size() > 2) void'(q.pop_front());
        run = (s == prev_s) ? run + 1 : 1;
        prev_s = s;
        e = '0;
        if (!pl) begin
            if (s && run == D + 1) begin
                pl = 1; e[4] = 1; anchor = t; wl = 0;
            end
        end else if (!s) begin
            if (run == D + 1) begin
                pl = 0; e[3] = 1; e[2] = !wl; wl = 0;
            end
        end else if (run == 1) begin
            anchor = t;
        end else if (!wl && t - anchor == L) begin
            wl = 1; e[1] = 1; anchor = t;
        end else if (wl && (t - anchor) % R == 0) begin
            e[0] = 1;
        end
        e[5] = pl;
        t++;
        #1 chk(tag, outs(), e);
    endtask

    task automatic do_rst();
        @(negedge clk30);
        rst = 1'b1;
        #1 chk("rst_async", outs(), 6'b0);
        model_reset();
        @(negedge clk30);
        rst = 1'b0;
    endtask

    task automatic hold(input logic b, input int n, input string tag);
        repeat (n) step(b, tag);
    endtask

    initial begin
        model_reset();
        #12 chk("reset", outs(), 6'b0);
        @(negedge clk30);
        rst = 1'b0;
        hold(1, 4, "idle");
        hold(0, 10, "click_low");
        hold(1, 12, "click_high");
        hold(0, 3, "glitch_low");
        hold(1, 10, "glitch_high");
        hold(0, 40, "long_low");
        hold(1, 12, "long_high");
        hold(0, 8, "bounce_press");
        hold(1, 2, "bounce_high");
        hold(0, 30, "bounce_low");
        hold(1, 12, "bounce_rel");
        hold(0, 30, "rst_long");
        do_rst();
        hold(0, 12, "rst_repress");
        hold(1, 12, "rst_release");
        for (int i = 0; i < 50; i++) step(i[0], "toggle");
        hold(1, 10, "toggle_end");
        for (int i = 0; i < 140; i++) begin
            int n;
            logic lv;
            if ($urandom_range(0, 29) == 0) do_rst();
            lv = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 8));
            hold(lv, n, "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Front-end conditioning stage for one raw, active-low board push-button. It synchronises and debounces the button, then emits single-cycle event strobes: press, release, click (short press), long-press and auto-repeat. It sits directly upstream of the LED counter/control FSMs, which consume clean strobes instead of raw button levels. Thresholds are given in clk30 cycles so benches can shrink them.

Parameters:
DEBOUNCE_CYC, 300000, consecutive stable samples needed to accept a press or release (10 ms at 30 MHz); must be >= 1
LONG_CYC, 15000000, cycles in HELD before long_pulse fires (500 ms); must be >= 1
REPEAT_CYC, 3000000, period of repeat_pulse while in LONG (100 ms); must be >= 1

Ports:
clk30  input  1  system clock, 30 MHz
rst  input  1  asynchronous, active-high reset
btn_n  input  1  raw button level, active-low (0 = pressed), asynchronous to clk30
pressed  output  1  debounced level; 1 in HELD, LONG and DB_RELEASE
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
click_pulse  output  1  one-cycle strobe on accepted release when LONG was never reached
long_pulse  output  1  one-cycle strobe on HELD->LONG
repeat_pulse  output  1  one-cycle strobe every REPEAT_CYC cycles in LONG

Behaviour:
- Reset is asserted by rst (asynchronous, active-high); clock is clk30.
- Reset values:
  - state = IDLE; cnt = 0; was_long = 0.
  - Both synchroniser flops = 1 (released).
  - All outputs = 0.
- Reset may assert mid-operation in any state. The block returns to IDLE and no pending strobe is emitted. After reset releases, a button that is still held is treated as a new press and must debounce again.
- Synchroniser: two flops; btn_s = inverted second-flop value (1 = pressed).
- cnt is a 32-bit up-counter shared by all states; it is cleared on every state change.
- Edge numbering: edge 0 is the first clk30 edge that samples btn_n = 0.
- IDLE:
  - btn_s = 1 -> DB_PRESS. This transition occurs at edge 2.
- DB_PRESS:
  - btn_s = 0 -> IDLE; no strobe (glitch rejected).
  - Else, if cnt == DEBOUNCE_CYC-1 -> HELD and press_pulse = 1 for one cycle.
  - Else cnt++.
  - A clean press therefore raises press_pulse after edge DEBOUNCE_CYC+2.
- HELD:
  - btn_s = 0 -> DB_RELEASE.
  - Else, if cnt == LONG_CYC-1 -> LONG, set was_long, and long_pulse = 1.
  - Else cnt++.
- LONG:
  - btn_s = 0 -> DB_RELEASE.
  - Else, if cnt == REPEAT_CYC-1 -> repeat_pulse = 1, cnt = 0, stay in LONG.
  - Else cnt++.
  - Repeats continue indefinitely; no wrap issue because cnt resets each period.
- DB_RELEASE:
  - btn_s = 1 (bounce) -> back to LONG if was_long, else HELD. No strobe; the hold/repeat timer restarts from 0.
  - Else, if cnt == DEBOUNCE_CYC-1 -> IDLE and release_pulse = 1. In the same cycle click_pulse = ~was_long. was_long is cleared.
  - Else cnt++.
- Strobe timing and exclusivity:
  - All strobes are registered and last exactly one cycle.
  - At most one of press/release/long/repeat is high in any cycle; click_pulse only coincides with release_pulse.
- pressed is registered and changes in the same cycle as press_pulse and release_pulse.
- Latency:
  - Press: DEBOUNCE_CYC+2 edges from the first low sample.
  - Release: DEBOUNCE_CYC+2 edges from the first high sample.
  - Long: LONG_CYC edges after press_pulse.

Test Plan:
(All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.)
1. btn_n low at edge 0, held for 10 cycles, then high at edge 10 -> press_pulse and pressed rise after edge 6; release_pulse and click_pulse after edge 16; pressed falls after edge 16; no long_pulse.
2. btn_n low for 3 cycles then high -> no strobes; pressed stays 0; state returns to IDLE.
3. Hold low for 40 cycles from edge 0 -> press at edge 6, long_pulse at edge 26, repeat_pulse at edges 31 and 36. Release -> release_pulse with click_pulse = 0.
4. After press accepted, btn_n bounces high 2 cycles, then low, then stays low -> no release_pulse; long_pulse arrives 20 edges after the bounce ends (timer restarted).
5. Assert rst during LONG -> all outputs 0 immediately. Deassert with btn_n still low -> fresh press_pulse 6 edges after the first post-reset sample; no long_pulse carried over.
6. btn_n toggling every cycle for 50 cycles -> zero strobes; pressed stays 0.
